// File: rtl/hilo_pkg.sv
// Shared types and encodings for the HI/LO multiply/divide sequencer.
package hilo_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDivArm,
        StDivWait,
        StCommit
    } hilo_state_e;

    localparam logic [2:0]  CMD_MULT = 3'd0;
    localparam logic [2:0]  CMD_DIV  = 3'd1;
    localparam logic [2:0]  CMD_MTHI = 3'd2;
    localparam logic [2:0]  CMD_MTLO = 3'd3;

    localparam logic [3:0]  ALUOP_ADD = 4'h0;
    localparam logic [3:0]  ALUOP_MUL = 4'h2;
    localparam logic [3:0]  ALUOP_DIV = 4'h3;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_seq.sv
// HI/LO owner that sequences MULT/DIV/MTHI/MTLO through the shared ALU.
// Optional divide watchdog is compiled in with HILO_DIV_TIMEOUT_EN.
module hilo_seq
    import hilo_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned DIV_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    output logic [3:0]    alu_aluop,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_res_high,
    input  logic [DW-1:0] alu_res_low,
    input  logic          alu_div_done,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo,
    output logic          busy,
    output logic          done,
    output logic          div0,
    output logic          timeout
);

    hilo_state_e state;

    if (DW != 32) begin : g_dw_check
        $error("hilo_seq supports DW == 32 only");
    end
    if (DIV_TIMEOUT == 0 || DIV_TIMEOUT > 255) begin : g_timeout_check
        $error("DIV_TIMEOUT must fit the 8-bit watchdog counter");
    end

    assign cmd_ready = (state == StIdle);
    assign busy      = ~cmd_ready;

`ifdef HILO_DIV_TIMEOUT_EN
    logic [7:0] wd_cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            alu_aluop <= ALUOP_ADD;
            alu_a     <= '0;
            alu_b     <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            div0      <= 1'b0;
            timeout   <= 1'b0;
`ifdef HILO_DIV_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        alu_a <= op_a;
                        alu_b <= op_b;
                        // Everything except MULT and a nonzero DIV retires directly.
                        state <= StCommit;
                        done  <= 1'b1;
                        case (cmd_op)
                            CMD_MULT: begin
                                state     <= StMul;
                                done      <= 1'b0;
                                alu_aluop <= ALUOP_MUL;
                            end
                            CMD_DIV: begin
                                if (op_b != '0) begin
                                    state     <= StDivArm;
                                    done      <= 1'b0;
                                    alu_aluop <= ALUOP_DIV;
                                end else begin
                                    hi   <= op_a;
                                    lo   <= DIV0_LO;
                                    div0 <= 1'b1;
                                end
                            end
                            CMD_MTHI: hi <= op_a;
                            CMD_MTLO: lo <= op_a;
                            default: ;
                        endcase
                    end
                end
                StMul: begin
                    hi        <= alu_res_high;
                    lo        <= alu_res_low;
                    alu_aluop <= ALUOP_ADD;
                    done      <= 1'b1;
                    state     <= StCommit;
                end
                StDivArm: begin
                    // A stale div_done seen here belongs to a previous operation.
`ifdef HILO_DIV_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= StDivWait;
                end
                StDivWait: begin
                    if (alu_div_done) begin
                        hi        <= alu_res_high;
                        lo        <= alu_res_low;
                        alu_aluop <= ALUOP_ADD;
                        done      <= 1'b1;
                        state     <= StCommit;
                    end
`ifdef HILO_DIV_TIMEOUT_EN
                    else if (wd_cnt == 8'(DIV_TIMEOUT - 1)) begin
                        timeout   <= 1'b1;
                        alu_aluop <= ALUOP_ADD;
                        done      <= 1'b1;
                        state     <= StCommit;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                StCommit: begin
                    state <= StIdle;
                end
                default: begin
                    state     <= StIdle;
                    alu_aluop <= ALUOP_ADD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_seq.sv
// Directed self-checking bench for hilo_seq with a small behavioural ALU model.
module tb_hilo_seq;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [3:0]  alu_aluop;
    logic [31:0] alu_a, alu_b, alu_res_high, alu_res_low, hi, lo;
    logic        alu_div_done, busy, done, div0, timeout;

    int n_cmp = 0;
    int n_err = 0;

    // ALU model: divider finishes on the 34th consecutive aluop==3 cycle.
    logic [7:0]  div_cnt = '0;
    logic        never_done = 1'b0;
    logic [63:0] prod;
    assign prod = {32'd0, alu_a} * {32'd0, alu_b};

    always @(posedge clk) begin
        if (alu_aluop == ALUOP_DIV) div_cnt <= div_cnt + 8'd1;
        else                        div_cnt <= '0;
    end

    always_comb begin
        alu_res_high = '0;
        alu_res_low  = '0;
        if (alu_aluop == ALUOP_MUL) begin
            alu_res_high = prod[63:32];
            alu_res_low  = prod[31:0];
        end else if (alu_aluop == ALUOP_DIV && alu_b != 0) begin
            alu_res_high = alu_a % alu_b;
            alu_res_low  = alu_a / alu_b;
        end
    end
    assign alu_div_done = !never_done && alu_aluop == ALUOP_DIV && div_cnt == 8'd33;

    hilo_seq #(.DW(32), .DIV_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .op_a(op_a), .op_b(op_b), .alu_aluop(alu_aluop),
        .alu_a(alu_a), .alu_b(alu_b), .alu_res_high(alu_res_high),
        .alu_res_low(alu_res_low), .alu_div_done(alu_div_done), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div0(div0), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one command on a negedge; it is accepted at the following posedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("ready_before_issue", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        op_a      = a;
        op_b      = b;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Counts cycles after accept until done, and how many had aluop 2 or 3.
    task automatic wait_done(input int max, output int lat, output int n2, output int n3);
        lat = 0; n2 = 0; n3 = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (alu_aluop == ALUOP_MUL) n2++;
            if (alu_aluop == ALUOP_DIV) n3++;
            if (done) break;
            if (lat >= max) begin
                check("done_within_bound", 0, 1);
                break;
            end
        end
    endtask

    int lat, n2, n3;

    initial begin
        // Reset state
        #2;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_aluop", alu_aluop, 0);
        check("rst_div0", div0, 0);
        @(negedge clk);
        rst = 1'b1;

        // MULT 0x10000 * 0x20000 = 0x2_0000_0000
        issue(CMD_MULT, 32'h0001_0000, 32'h0002_0000);
        wait_done(10, lat, n2, n3);
        check("mul_latency", lat, 2);
        check("mul_aluop2_cycles", n2, 1);
        check("mul_hi", hi, 32'h2);
        check("mul_lo", lo, 32'h0);
        check("mul_aluop_commit", alu_aluop, 0);
        @(negedge clk);
        check("mul_done_pulse", done, 0);
        check("mul_ready_after", cmd_ready, 1);

        // DIV 100/7 with a competing MTHI held on cmd_valid throughout
        issue(CMD_DIV, 32'd100, 32'd7);
        cmd_valid = 1'b1; cmd_op = CMD_MTHI; op_a = 32'hDEAD;
        wait_done(100, lat, n2, n3);
        cmd_valid = 1'b0;
        check("div_aluop3_cycles", n3, 34);
        check("div_latency", lat, 35);
        check("div_lo", lo, 14);
        check("div_hi", hi, 2);
        check("div_aluop_commit", alu_aluop, 0);
        @(negedge clk);
        check("div_ignored_valid_hi", hi, 2);
        check("div2_aluop_before", alu_aluop, 0);

        // Back-to-back DIV 50/5
        issue(CMD_DIV, 32'd50, 32'd5);
        wait_done(100, lat, n2, n3);
        check("div2_aluop3_cycles", n3, 34);
        check("div2_lo", lo, 10);
        check("div2_hi", hi, 0);
        check("div2_div0", div0, 0);

        // Divide by zero, then MTHI/MTLO/NOP
        issue(CMD_DIV, 32'h1234, 32'd0);
        wait_done(10, lat, n2, n3);
        check("div0_latency", lat, 1);
        check("div0_no_alu", n3, 0);
        check("div0_hi", hi, 32'h1234);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_flag", div0, 1);
        issue(CMD_MTHI, 32'hA5, 32'd0);
        wait_done(10, lat, n2, n3);
        check("mthi_latency", lat, 1);
        check("mthi_hi", hi, 32'hA5);
        check("mthi_lo_kept", lo, 32'hFFFF_FFFF);
        check("div0_sticky", div0, 1);
        issue(CMD_MTLO, 32'h5A, 32'd0);
        wait_done(10, lat, n2, n3);
        check("mtlo_lo", lo, 32'h5A);
        check("mtlo_hi_kept", hi, 32'hA5);
        issue(3'd6, 32'h777, 32'h888);
        wait_done(10, lat, n2, n3);
        check("nop_latency", lat, 1);
        check("nop_hi", hi, 32'hA5);
        check("nop_lo", lo, 32'h5A);

        never_done = 1'b1;
`ifdef HILO_DIV_TIMEOUT_EN
        issue(CMD_DIV, 32'd9, 32'd3);
        wait_done(100, lat, n2, n3);
        check("wd_aluop3_cycles", n3, 17);
        check("wd_timeout", timeout, 1);
        check("wd_hi_kept", hi, 32'hA5);
        check("wd_lo_kept", lo, 32'h5A);
`else
        check("timeout_tied", timeout, 0);
`endif

        // Reset while stuck in DIV_WAIT
        issue(CMD_DIV, 32'd9, 32'd3);
        repeat (5) @(negedge clk);
        check("midwait_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("midrst_ready", cmd_ready, 1);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_aluop", alu_aluop, 0);
        check("midrst_div0", div0, 0);
        check("midrst_timeout", timeout, 0);
        repeat (2) @(negedge clk);
        check("midrst_no_done", done, 0);
        rst = 1'b1;
        never_done = 1'b0;

        // Sanity after reset: 3 * 5
        issue(CMD_MULT, 32'd3, 32'd5);
        wait_done(10, lat, n2, n3);
        check("post_mul_lo", lo, 15);
        check("post_mul_hi", hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/hilo_seq.md
Name: hilo_seq

Overview:
- Sequencer for the multi-cycle core's ALU multiply/divide path, owning the architectural HI/LO registers.
- Accepts one MULT/DIV/MTHI/MTLO command at a time from the control unit and drives the ALU's aluop/a/b inputs.
- Arms the ALU's start-on-opcode-change divider, waits for divDone, then commits res_high/res_low into HI/LO.
- Asserts busy so the control FSM stalls the core while an operation is in flight.

Parameters:
- DW, 32, datapath width; only 32 is supported.
- DIV_TIMEOUT, 64, watchdog limit in cycles for DIV_WAIT; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high at an edge.
- cmd_op  in  3  0=MULT, 1=DIV, 2=MTHI, 3=MTLO, others=NOP (accepted; no effect except done).
- op_a  in  32  rs operand.
- op_b  in  32  rt operand.
- alu_aluop  out  4  opcode to the ALU.
- alu_a  out  32  operand A to the ALU, from a register.
- alu_b  out  32  operand B to the ALU, from a register.
- alu_res_high  in  32  ALU high result (mul hi / div remainder).
- alu_res_low  in  32  ALU low result (mul lo / div quotient).
- alu_div_done  in  1  ALU divider completion.
- hi  out  32  HI register, used by MFHI.
- lo  out  32  LO register, used by MFLO.
- busy  out  1  equals ~cmd_ready.
- done  out  1  one-cycle pulse after HI/LO commit.
- div0  out  1  sticky flag, set by a divide-by-zero command.
- timeout  out  1  sticky flag; present only with the optional feature, otherwise tied 0.

Behaviour:
Reset (rst low, asynchronous):
- State goes to IDLE.
- hi, lo, alu_a, alu_b, div0, timeout all go to 0.
- done goes to 0 and alu_aluop to 4'h0.
- An in-flight operation is dropped silently; its result is never committed.

States IDLE, MUL, DIV_ARM, DIV_WAIT, COMMIT:
- IDLE: alu_aluop=4'h0 (add).
  - On accept, latch op_a/op_b into the operand registers.
  - MULT: go to MUL.
  - DIV with op_b!=0: go to DIV_ARM.
  - DIV with op_b==0: no ALU use; hi<=op_a, lo<=32'hFFFF_FFFF, div0<=1, go to COMMIT.
  - MTHI: hi<=op_a, go to COMMIT. MTLO: lo<=op_a, go to COMMIT. NOP: go to COMMIT.
- MUL: alu_aluop=4'h2. At the edge: hi<=alu_res_high, lo<=alu_res_low, go to COMMIT. Accept-to-done latency is 2 cycles.
- DIV_ARM: alu_aluop=4'h3, held for exactly one cycle. The previous cycle drove aluop!=3, so the ALU's start pulse fires. Then go to DIV_WAIT.
- DIV_WAIT: alu_aluop=4'h3, held until alu_div_done is sampled high. At that edge: hi<=alu_res_high (remainder), lo<=alu_res_low (quotient), go to COMMIT.
  - An alu_div_done that is already high in DIV_ARM is ignored.
- COMMIT: alu_aluop=4'h0, done=1 for this cycle only; go to IDLE.
  - Because of COMMIT, back-to-back DIVs always see at least two non-3 cycles between them, so the divider re-arms correctly.

Other rules:
- cmd_valid outside IDLE is ignored; the requester holds the command until it is accepted.
- Operand registers hold their value until the next accept; alu_a/alu_b are stable for the whole operation.
- Signed/unsigned semantics belong to the ALU; this block does no arithmetic except the b==0 compare.
- div0 and timeout clear only on reset.

Optional Feature:
- Macro: HILO_DIV_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on DIV_ARM and increments each DIV_WAIT cycle.
  - If it reaches DIV_TIMEOUT without alu_div_done: go to COMMIT, hi/lo unchanged, timeout<=1.
  - If done and the limit occur in the same cycle, done wins.
- When undefined: no counter; DIV_WAIT waits indefinitely; timeout is tied 0.

Decomposition:
- Package hilo_pkg holds:
  - the state enum;
  - cmd_op codes CMD_MULT/CMD_DIV/CMD_MTHI/CMD_MTLO;
  - ALUOP_ADD=4'h0, ALUOP_MUL=4'h2, ALUOP_DIV=4'h3;
  - DIV0_LO=32'hFFFF_FFFF.
- Single module; no sub-module. The watchdog is small enough to stay inline under the macro.

Test Plan:
- Reset mid-DIV_WAIT: pulse rst low -> hi=lo=0, state IDLE, cmd_ready=1 immediately (asynchronous), no done.
- MULT a=0x0001_0000, b=0x0002_0000 with an ALU model -> alu_aluop=2 one cycle, hi=0x2, lo=0x0, done exactly 2 cycles after accept.
- DIV a=100, b=7, ALU model done after 33 cycles -> aluop sequence 0,3(×34),0; lo=14, hi=2; done 1 cycle after divDone; cmd_valid ignored throughout.
- Back-to-back DIVs (100/7 then 50/5) -> second DIV_ARM preceded by aluop 0; second result lo=10, hi=0.
- DIV b=0, a=0x1234 -> no aluop=3 cycle; hi=0x1234, lo=0xFFFF_FFFF, div0=1 and sticky; MTHI 0xA5 then MTLO 0x5A -> hi=0xA5, lo=0x5A, done each.
- With HILO_DIV_TIMEOUT_EN, DIV_TIMEOUT=16, ALU model never asserts done -> COMMIT after 16 DIV_WAIT cycles; timeout=1; hi/lo keep prior values.
